// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pc/instr pipeline with valid/ready bubble collapse and partial flush; latency DEPTH edges.
// Backpressure: ready ripples combinationally from out_ready back to in_ready; a stalled stage holds.
module pipe_stage_chain #(
   parameter  int LEN   = 32,
   parameter  int DEPTH = 4,
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [LEN-1:0]  in_pc,
   input  logic [LEN-1:0]  in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LEN-1:0]  out_pc,
   output logic [LEN-1:0]  out_instr,
   input  logic            flush_en,
   input  logic [IW-1:0]   flush_upto,
   output logic [CW-1:0]   occupancy,
   output logic [15:0]     killed_count
);

   logic [DEPTH-1:0] stage_valid;
   logic [LEN-1:0]   stage_pc    [DEPTH];
   logic [LEN-1:0]   stage_instr [DEPTH];

   logic [DEPTH:0]   rdy;
   logic [DEPTH-1:0] move;
   logic [DEPTH-1:0] load_en;
   logic [DEPTH-1:0] valid_nxt;
   logic [LEN-1:0]   src_pc    [DEPTH];
   logic [LEN-1:0]   src_instr [DEPTH];
   logic             accept;
   logic             transfer;
   int               fu;
   logic [CW-1:0]    occ_nxt;
   logic [3:0]       kill_add;
   logic [16:0]      kill_sum;

   // A stage is ready when it is empty or everything downstream of it can move.
   always_comb begin
      logic acc;
      acc        = out_ready;
      rdy[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         acc    = acc | ~stage_valid[i];
         rdy[i] = acc;
      end
   end

   assign in_ready  = rdy[0];
   assign accept    = in_valid & rdy[0];
   assign transfer  = stage_valid[DEPTH-1] & out_ready;
   assign out_valid = stage_valid[DEPTH-1];
   assign out_pc    = stage_pc[DEPTH-1];
   assign out_instr = stage_instr[DEPTH-1];

   always_comb begin
      fu = (int'(flush_upto) >= DEPTH) ? DEPTH - 1 : int'(flush_upto);
   end

   always_comb begin
      move[0]      = accept;
      src_pc[0]    = in_pc;
      src_instr[0] = in_instr;
      for (int j = 1; j < DEPTH; j++) begin
         move[j]      = stage_valid[j-1] & rdy[j];
         src_pc[j]    = stage_pc[j-1];
         src_instr[j] = stage_instr[j-1];
      end
   end

   // A beat leaving a killed stage dies too, so stage fu+1 keeps only its own stalled beat.
   always_comb begin
      valid_nxt = '0;
      load_en   = '0;
      for (int j = 0; j < DEPTH; j++) begin
         load_en[j]   = move[j] & ~(flush_en & (j <= fu + 1));
         valid_nxt[j] = ~(flush_en & (j <= fu)) &
                        (load_en[j] | (stage_valid[j] & ~rdy[j+1]));
      end
   end

   // A beat handed downstream in the flush cycle completed, so it is not counted as killed.
   always_comb begin
      kill_add = '0;
      if (flush_en) begin
         for (int j = 0; j < DEPTH; j++) begin
            if ((j <= fu) && stage_valid[j] && !((j == DEPTH - 1) && transfer))
               kill_add = kill_add + 4'd1;
         end
         if (accept)
            kill_add = kill_add + 4'd1;
      end
      kill_sum = {1'b0, killed_count} + 17'(kill_add);
   end

   always_comb begin
      occ_nxt = '0;
      for (int j = 0; j < DEPTH; j++)
         occ_nxt = occ_nxt + CW'(valid_nxt[j]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stage_valid  <= '0;
         occupancy    <= '0;
         killed_count <= '0;
         for (int j = 0; j < DEPTH; j++) begin
            stage_pc[j]    <= '0;
            stage_instr[j] <= '0;
         end
      end else begin
         stage_valid  <= valid_nxt;
         occupancy    <= occ_nxt;
         killed_count <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
         for (int j = 0; j < DEPTH; j++) begin
            if (load_en[j]) begin
               stage_pc[j]    <= src_pc[j];
               stage_instr[j] <= src_instr[j];
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain at DEPTH=4, LEN=32 with hand-computed expectations.
module tb_pipe_stage_chain;
   localparam int LEN   = 32;
   localparam int DEPTH = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [LEN-1:0]  in_pc = '0;
   logic [LEN-1:0]  in_instr = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [LEN-1:0]  out_pc;
   logic [LEN-1:0]  out_instr;
   logic            flush_en = 1'b0;
   logic [1:0]      flush_upto = '0;
   logic [2:0]      occupancy;
   logic [15:0]     killed_count;

   int n_cmp = 0;
   int n_err = 0;

   pipe_stage_chain #(.LEN(LEN), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .flush_en(flush_en), .flush_upto(flush_upto),
      .occupancy(occupancy), .killed_count(killed_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] ins(input logic [31:0] p);
      return p ^ 32'hC0DE_0000;
   endfunction

   task automatic drive(input logic v, input logic [31:0] p);
      in_valid = v;
      in_pc    = p;
      in_instr = ins(p);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset held: outputs idle, presented beat not captured
      drive(1'b1, 32'h77);
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_occ", occupancy, 0);
      check("rst_killed", killed_count, 0);
      tick;
      check("rst_no_capture", occupancy, 0);
      drive(1'b0, 0);
      reset = 1'b1;

      // streaming
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 4 * k);
         #1;
         check("stream_in_ready", in_ready, 1);
         tick;
         if (k + 1 < 4) begin
            check("stream_fill_valid", out_valid, 0);
            check("stream_fill_occ", occupancy, k + 1);
         end else begin
            check("stream_valid", out_valid, 1);
            check("stream_pc", out_pc, 4 * (k - 3));
            check("stream_instr", out_instr, ins(4 * (k - 3)));
            check("stream_occ", occupancy, 4);
         end
      end
      drive(1'b0, 0);
      repeat (4) tick;
      check("drain_occ", occupancy, 0);
      check("drain_valid", out_valid, 0);
      check("drain_killed", killed_count, 0);

      // backpressure
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 4 * k);
         tick;
      end
      drive(1'b1, 16);
      #1;
      check("bp_in_ready_low", in_ready, 0);
      check("bp_occ", occupancy, 4);
      check("bp_out_pc", out_pc, 0);
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_comb", in_ready, 1);
      tick;
      check("bp_after_pc", out_pc, 4);
      check("bp_after_occ", occupancy, 4);

      // partial flush of stages 0..1 while stalled
      out_ready  = 1'b0;
      drive(1'b0, 0);
      flush_en   = 1'b1;
      flush_upto = 2'd1;
      tick;
      flush_en = 1'b0;
      check("pflush_occ", occupancy, 2);
      check("pflush_killed", killed_count, 2);
      check("pflush_out_pc", out_pc, 4);
      check("pflush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      tick;
      check("pflush_next_pc", out_pc, 8);
      check("pflush_next_occ", occupancy, 1);
      tick;
      check("pflush_empty", occupancy, 0);

      // bubble collapse
      out_ready = 1'b0;
      drive(1'b1, 32'h10); tick;
      drive(1'b0, 0); tick; tick;
      drive(1'b1, 32'h20); tick;
      drive(1'b0, 0); repeat (3) tick;
      check("bub_pc", out_pc, 32'h10);
      check("bub_occ", occupancy, 2);
      check("bub_in_ready", in_ready, 1);
      out_ready = 1'b1;
      tick;
      check("bub_adjacent_valid", out_valid, 1);
      check("bub_adjacent_pc", out_pc, 32'h20);
      check("bub_adjacent_occ", occupancy, 1);
      tick;
      check("bub_empty", occupancy, 0);

      // full flush concurrent with a transfer and an accepted input
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h100 + 4 * k);
         tick;
      end
      check("ff_full", occupancy, 4);
      out_ready  = 1'b1;
      drive(1'b1, 32'h200);
      flush_en   = 1'b1;
      flush_upto = 2'd3;
      #1;
      check("ff_in_ready", in_ready, 1);
      check("ff_out_pc", out_pc, 32'h100);
      tick;
      flush_en = 1'b0;
      drive(1'b0, 0);
      check("ff_occ", occupancy, 0);
      check("ff_valid", out_valid, 0);
      check("ff_killed", killed_count, 6);

      // flush_upto=0 on a stalled full pipe: blocked input is not counted
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h300 + 4 * k);
         tick;
      end
      drive(1'b1, 32'h400);
      flush_en   = 1'b1;
      flush_upto = 2'd0;
      tick;
      check("f0_occ", occupancy, 3);
      check("f0_killed", killed_count, 7);
      check("f0_out_pc", out_pc, 32'h300);
      drive(1'b0, 0);
      out_ready  = 1'b1;
      flush_upto = 2'd1;
      tick;
      check("f1_occ", occupancy, 1);
      check("f1_killed", killed_count, 8);
      check("f1_out_pc", out_pc, 32'h304);
      flush_upto = 2'd3;
      tick;
      flush_en = 1'b0;
      check("f3_xfer_occ", occupancy, 0);
      check("f3_xfer_not_killed", killed_count, 8);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h500 + 4 * k);
         tick;
      end
      drive(1'b0, 0);
      tick;
      check("mr_occ_before", occupancy, 3);
      check("mr_valid_before", out_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      check("mr_valid_async", out_valid, 0);
      check("mr_occ_async", occupancy, 0);
      check("mr_killed_async", killed_count, 0);
      check("mr_in_ready", in_ready, 1);
      drive(1'b1, 32'h600);
      tick;
      check("mr_no_capture", occupancy, 0);
      reset = 1'b1;
      drive(1'b1, 32'h700);
      tick;
      check("mr_resume_occ", occupancy, 1);
      drive(1'b0, 0);
      repeat (3) tick;
      check("mr_resume_valid", out_valid, 1);
      check("mr_resume_pc", out_pc, 32'h700);
      check("mr_resume_instr", out_instr, ins(32'h700));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
